data_mem_responder: RTL and testbench

- Memory-side responder for the core's data-memory request interface: request, we_re, mask, address, store data in; load data and valid out.
- Holds a word-addressed, byte-maskable storage array and answers each request after a programmable number of wait cycles.
- Sits outside the core in the SoC/testbench top, directly on the core's data_mem_* / DM_* ports.
- Serves as the synthesizable data memory model for the multi-cycle memory handshake.

---
 rtl/dmem_pkg.sv | 31 +++
 rtl/dmem_byte_array.sv | 56 +++++
 rtl/data_mem_responder.sv | 114 +++++++++++
 tb/tb_data_mem_responder.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared types and constants for the data-memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    // Plain-vector aliases of the state encoding for logic-typed state registers
    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_WAIT = WAIT;
    localparam logic [1:0] ST_RESP = RESP;

    localparam logic WE_WRITE = 1'b1;
    localparam logic WE_READ  = 1'b0;

    localparam logic [3:0] MASK_BYTE0 = 4'b0001;
    localparam logic [3:0] MASK_HALF0 = 4'b0011;
    localparam logic [3:0] MASK_WORD  = 4'b1111;

    localparam int NUM_LANES = 4;
    localparam int CNT_W     = 4;

endpackage
`default_nettype wire

// File: rtl/dmem_byte_array.sv
`default_nettype none
// ============================================================================
// Module      : dmem_byte_array
// Description : DEPTH x 4 byte-lane storage, per-lane write enable and a
//               registered read port that zeroes deselected lanes.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_byte_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_LANES-1:0]     wr_en,
    input  logic [IDX_W-1:0]         wr_idx,
    input  logic [NUM_LANES*8-1:0]   wr_data,
    input  logic                     rd_en,
    input  logic [NUM_LANES-1:0]     rd_lane_en,
    input  logic [IDX_W-1:0]         rd_idx,
    output logic [NUM_LANES*8-1:0]   rd_data
);

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        logic [7:0] mem [DEPTH];
        logic [7:0] rd_q;
        logic [7:0] rd_d;

        always_ff @(posedge clk) begin
            if (wr_en[i]) begin
                mem[wr_idx] <= wr_data[8*i +: 8];
            end
        end

        // Read register only moves on a read response; it holds otherwise
        always_comb begin
            rd_d = rd_q;
            if (rd_en) begin
                rd_d = rd_lane_en[i] ? mem[rd_idx] : 8'h00;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                rd_q <= 8'h00;
            end else begin
                rd_q <= rd_d;
            end
        end

        assign rd_data[8*i +: 8] = rd_q;
    end

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder
// Description : Byte-maskable data memory answering each core request after
//               LATENCY wait cycles with a one-cycle valid strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDRESS    = 32,
    parameter int DEPTH      = 1024,
    parameter int LATENCY    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  request,
    input  logic                  we_re,
    input  logic [3:0]            mask,
    input  logic [ADDRESS-1:0]    address,
    input  logic [DATA_WIDTH-1:0] store_data,
    output logic [DATA_WIDTH-1:0] load_data,
    output logic                  valid,
    output logic                  busy
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q,   cnt_d;
    logic                  we_q,    we_d;
    logic [3:0]            mask_q,  mask_d;
    logic [IDX_W-1:0]      idx_q,   idx_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

    logic                  unused_addr;
    assign unused_addr = ^{address[ADDRESS-1:IDX_W+2], address[1:0]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        mask_d  = mask_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (request) begin
                    we_d    = we_re;
                    mask_d  = mask;
                    idx_d   = address[IDX_W+1:2];
                    wdata_d = store_data;
                    cnt_d   = CNT_W'(LATENCY);
                    state_d = (LATENCY == 0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q <= 4'd1) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            mask_q  <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            mask_q  <= mask_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
        end
    end

    // The read fires on the edge entering RESP so data is present during RESP;
    // the *_d view covers the zero-latency case where capture happens on that edge.
    logic                 rd_en;
    logic [NUM_LANES-1:0] wr_en;

    assign rd_en = (state_d == ST_RESP) && (state_q != ST_RESP) && (we_d == WE_READ);
    assign wr_en = ((state_q == ST_RESP) && (we_q == WE_WRITE) && !rst) ? mask_q : '0;

    dmem_byte_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_idx     (idx_q),
        .wr_data    (wdata_q),
        .rd_en      (rd_en),
        .rd_lane_en (mask_d),
        .rd_idx     (idx_d),
        .rd_data    (load_data)
    );

    assign valid = (state_q == ST_RESP);
    assign busy  = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_responder
// Description : Three responders (LATENCY 0/1/3) on one request stream,
//               checked every cycle against an edge-count transaction model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;
    import dmem_pkg::*;

    localparam int NI    = 3;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        request = 1'b0;
    logic        we_re = 1'b0;
    logic [3:0]  mask = 4'h0;
    logic [31:0] address = 32'h0;
    logic [31:0] store_data = 32'h0;

    logic [NI-1:0]       dv, db;
    logic [NI-1:0][31:0] dl;

    always #5 clk = ~clk;

    data_mem_responder #(.DATA_WIDTH(32), .ADDRESS(32), .DEPTH(DEPTH), .LATENCY(0)) u_l0 (
        .clk(clk), .rst(rst), .request(request), .we_re(we_re), .mask(mask),
        .address(address), .store_data(store_data),
        .load_data(dl[0]), .valid(dv[0]), .busy(db[0]));
    data_mem_responder #(.DATA_WIDTH(32), .ADDRESS(32), .DEPTH(DEPTH), .LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst), .request(request), .we_re(we_re), .mask(mask),
        .address(address), .store_data(store_data),
        .load_data(dl[1]), .valid(dv[1]), .busy(db[1]));
    data_mem_responder #(.DATA_WIDTH(32), .ADDRESS(32), .DEPTH(DEPTH), .LATENCY(3)) u_l3 (
        .clk(clk), .rst(rst), .request(request), .we_re(we_re), .mask(mask),
        .address(address), .store_data(store_data),
        .load_data(dl[2]), .valid(dv[2]), .busy(db[2]));

    function automatic int lat(input int j);
        if (j == 0) return 0;
        if (j == 1) return 1;
        return 3;
    endfunction

    // Transaction model: one outstanding request per instance, located by edge count
    int          ecount = 0;
    bit          act    [NI];
    int          aedge  [NI];
    bit          cwe    [NI];
    logic [3:0]  cmask  [NI];
    int          cidx   [NI];
    logic [31:0] cdata  [NI];
    logic [7:0]  mm     [NI][DEPTH][4];
    bit          exp_v  [NI];
    bit          exp_b  [NI];
    logic [31:0] exp_l  [NI];

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;
    int vcnt [NI];

    task automatic model_step();
        int off;
        ecount++;
        for (int j = 0; j < NI; j++) begin
            if (rst) begin
                act[j]   = 1'b0;
                exp_v[j] = 1'b0;
                exp_b[j] = 1'b0;
                exp_l[j] = 32'h0;
            end else begin
                off = ecount - aedge[j];
                if (act[j] && off == lat(j) + 1) begin
                    if (cwe[j])
                        for (int b = 0; b < 4; b++)
                            if (cmask[j][b]) mm[j][cidx[j]][b] = cdata[j][8*b +: 8];
                    act[j] = 1'b0;
                end else if (!act[j] && request) begin
                    act[j]   = 1'b1;
                    aedge[j] = ecount;
                    cwe[j]   = we_re;
                    cmask[j] = mask;
                    cidx[j]  = int'(address[11:2]);
                    cdata[j] = store_data;
                end
                off = ecount - aedge[j];
                exp_v[j] = act[j] && (off == lat(j));
                exp_b[j] = act[j];
                if (exp_v[j] && !cwe[j])
                    for (int b = 0; b < 4; b++)
                        exp_l[j][8*b +: 8] = cmask[j][b] ? mm[j][cidx[j]][b] : 8'h00;
            end
        end
    endtask

    initial begin
        for (int j = 0; j < NI; j++) begin
            act[j] = 1'b0; aedge[j] = 0; vcnt[j] = 0;
        end
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    task automatic chk(input string name, input int j, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s[%0d] t=%0t: got %h expected %h", name, j, $time, got, want);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                for (int j = 0; j < NI; j++) begin
                    chk("valid", j, 32'(dv[j]), 32'(exp_v[j]));
                    chk("busy", j, 32'(db[j]), 32'(exp_b[j]));
                    chk("load_data", j, dl[j], exp_l[j]);
                    if (dv[j]) vcnt[j]++;
                end
            end
        end
    end

    task automatic wait_idle();
        for (int k = 0; k < 20; k++) begin
            if (!act[0] && !act[1] && !act[2]) return;
            @(negedge clk);
        end
        chk("idle_timeout", -1, 32'd1, 32'd0);
    endtask

    // Returns on the negedge just after the accepting edge
    task automatic txn(input logic w, input logic [3:0] m, input logic [31:0] a, input logic [31:0] d);
        wait_idle();
        we_re = w; mask = m; address = a; store_data = d; request = 1'b1;
        @(negedge clk);
        request = 1'b0;
    endtask

    initial begin
        #2ms;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int base [NI];
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk("reset_load", 1, dl[1], 32'h0);
        chk("reset_valid", 1, 32'(dv[1]), 32'h0);
        chk("reset_busy", 1, 32'(db[1]), 32'h0);
        rst = 1'b0;

        for (int i = 0; i < DEPTH; i++)
            txn(WE_WRITE, MASK_WORD, i * 4, 32'hA500_0000 | i);

        txn(WE_WRITE, MASK_WORD, 32'h10, 32'hDEAD_BEEF);
        txn(WE_READ, MASK_WORD, 32'h10, 32'h0);
        chk("l0_resp_cycle", 0, 32'(dv[0]), 32'h1);
        chk("l1_wait_cycle", 1, 32'(dv[1]), 32'h0);
        @(negedge clk);
        chk("l1_resp_cycle", 1, 32'(dv[1]), 32'h1);
        wait_idle();
        chk("rd_0x10", 1, dl[1], 32'hDEAD_BEEF);
        chk("model_0x10", 1, exp_l[1], 32'hDEAD_BEEF);

        txn(WE_WRITE, MASK_WORD, 32'h20, 32'h1122_3344);
        txn(WE_WRITE, 4'b0100, 32'h20, 32'h00AA_0000);
        txn(WE_READ, MASK_WORD, 32'h20, 32'h0);
        wait_idle();
        chk("rd_0x20_word", 1, dl[1], 32'h11AA_3344);
        chk("model_0x20", 2, exp_l[2], 32'h11AA_3344);
        txn(WE_READ, MASK_HALF0, 32'h20, 32'h0);
        wait_idle();
        chk("rd_0x20_half", 1, dl[1], 32'h0000_3344);

        // Request held high for 20 edges: one response per LATENCY+2 cycles
        wait_idle();
        for (int j = 0; j < NI; j++) base[j] = vcnt[j];
        we_re = WE_READ; mask = MASK_WORD; address = 32'h0; request = 1'b1;
        repeat (20) @(negedge clk);
        request = 1'b0;
        wait_idle();
        @(negedge clk);
        chk("pulses_l0", 0, 32'(vcnt[0] - base[0]), 32'd10);
        chk("pulses_l1", 1, 32'(vcnt[1] - base[1]), 32'd7);
        chk("pulses_l3", 2, 32'(vcnt[2] - base[2]), 32'd4);

        txn(WE_WRITE, MASK_BYTE0, 32'h1000, 32'h0000_0055);
        txn(WE_READ, MASK_WORD, 32'h0, 32'h0);
        wait_idle();
        chk("wrap_rd", 1, dl[1], 32'hA500_0055);

        txn(WE_WRITE, MASK_WORD, 32'h40, 32'hCAFE_BABE);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 1, 32'(db[1]), 32'h0);
        chk("abort_valid", 1, 32'(dv[1]), 32'h0);
        txn(WE_READ, MASK_WORD, 32'h40, 32'h0);
        wait_idle();
        chk("abort_rd", 1, dl[1], 32'hA500_0010);

        txn(WE_READ, 4'b0000, 32'h40, 32'h0);
        @(negedge clk);
        chk("mask0_valid", 1, 32'(dv[1]), 32'h1);
        chk("mask0_load", 1, dl[1], 32'h0);
        @(negedge clk);
        chk("mask0_busy", 1, 32'(db[1]), 32'h0);

        for (int c = 0; c < 3000; c++) begin
            request    = ($urandom_range(0, 1) == 1);
            we_re      = $urandom_range(0, 1) == 1;
            mask       = 4'($urandom_range(0, 15));
            address    = $urandom;
            store_data = $urandom;
            rst        = ($urandom_range(0, 199) == 0);
            @(negedge clk);
        end
        request = 1'b0;
        rst = 1'b0;
        wait_idle();
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
